// File: rtl/clmul_sequencer.sv
// Shared RISC-V constants and the ALU operation encoding, followed by the
// multi-cycle carry-less multiply sequencer that sits beside the single-cycle ALU.
package riscv_pkg;

  parameter int unsigned WIDTH = 64;

  typedef enum logic [6:0] {
    ALU_ADD    = 7'd0,
    ALU_SUB    = 7'd1,
    ALU_XOR    = 7'd2,
    ALU_OR     = 7'd3,
    ALU_AND    = 7'd4,
    ALU_SLL    = 7'd5,
    ALU_SRL    = 7'd6,
    ALU_SRA    = 7'd7,
    ALU_SLT    = 7'd8,
    ALU_SLTU   = 7'd9,
    ALU_CLMUL  = 7'd10,
    ALU_CLMULH = 7'd11,
    ALU_CLMULR = 7'd12
  } op_alu_e;

endpackage

module clmul_sequencer #(
  parameter int unsigned WIDTH          = riscv_pkg::WIDTH,
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [6:0]       req_op_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic             flush_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_err_o,
  output logic             busy_o
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (BITS_PER_CYCLE == 0 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("clmul_sequencer: BITS_PER_CYCLE must divide WIDTH");
  end

  logic [1:0]         state;
  logic [2*WIDTH-1:0] a;
  logic [WIDTH-1:0]   b;
  logic [6:0]         op;
  logic [2*WIDTH-1:0] prod;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   result;
  logic               err;

  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH-1:0]   sel;
  logic               last;
  logic               req_is_clmul;

  assign req_is_clmul = (req_op_i == riscv_pkg::ALU_CLMUL)  ||
                        (req_op_i == riscv_pkg::ALU_CLMULH) ||
                        (req_op_i == riscv_pkg::ALU_CLMULR);

  assign last = (cnt == CNT_W'(N - 1));

  // a is pre-shifted left and b shifted right each cycle, so bit i of b here
  // is rs2 bit cnt*BITS_PER_CYCLE+i and a already carries that base shift.
  always_comb begin
    prod_step = prod;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (b[i]) begin
        prod_step = prod_step ^ (a << i);
      end
    end
  end

  always_comb begin
    sel = '0;
    case (op)
      riscv_pkg::ALU_CLMUL:  sel = prod_step[WIDTH-1:0];
      riscv_pkg::ALU_CLMULH: sel = prod_step[2*WIDTH-1:WIDTH];
      riscv_pkg::ALU_CLMULR: sel = prod_step[2*WIDTH-2:WIDTH-1];
      default:               sel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a      <= '0;
      b      <= '0;
      op     <= '0;
      prod   <= '0;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else if (flush_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            a    <= {{WIDTH{1'b0}}, req_a_i};
            b    <= req_b_i;
            op   <= req_op_i;
            prod <= '0;
            cnt  <= '0;
            if (req_is_clmul) begin
              state <= S_RUN;
              err   <= 1'b0;
            end else begin
              state  <= S_DONE;
              err    <= 1'b1;
              result <= '0;
            end
          end
        end
        S_RUN: begin
          prod <= prod_step;
          a    <= a << BITS_PER_CYCLE;
          b    <= b >> BITS_PER_CYCLE;
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            state  <= S_DONE;
            result <= sel;
          end
        end
        S_DONE: begin
          if (rsp_ready_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = !rst && (state == S_IDLE) && !flush_i;
  assign rsp_valid_o  = !rst && (state == S_DONE);
  assign busy_o       = !rst && (state != S_IDLE);
  assign rsp_err_o    = !rst && err;
  assign rsp_result_o = rst ? '0 : result;

endmodule

// File: tb/tb_clmul_sequencer.sv
// Self-checking bench for clmul_sequencer: directed scenarios plus randomized
// operations compared against a bit-serial carry-less multiply reference model.
module tb_clmul_sequencer;
  import riscv_pkg::*;

  localparam int W   = 64;
  localparam int BPC = 4;
  localparam int N   = W / BPC;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [6:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         flush;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_err;
  logic         busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  clmul_sequencer #(
    .WIDTH(W),
    .BITS_PER_CYCLE(BPC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .flush_i     (flush),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_result_o(rsp_result),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Reference: {err, result} from the textbook definition of carry-less multiply.
  function automatic logic [W:0] model(input logic [6:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = '0;
    for (int i = 0; i < W; i++) begin
      if (b[i]) p = p ^ ({{W{1'b0}}, a} << i);
    end
    if (op == ALU_CLMUL)       return {1'b0, p[W-1:0]};
    else if (op == ALU_CLMULH) return {1'b0, p[2*W-1:W]};
    else if (op == ALU_CLMULR) return {1'b0, p[2*W-2:W-1]};
    else                       return {1'b1, {W{1'b0}}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Waits (bounded) for ready, presents one request for one cycle.
  task automatic launch(input logic [6:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int w;
    w = 0;
    while (req_ready !== 1'b1 && w < 50) begin
      step();
      w++;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    step();
    req_valid = 1'b0;
    req_a     = W'($urandom) << 32 | W'($urandom);
    req_b     = W'($urandom);
  endtask

  // Cycles from the accept edge until rsp_valid is seen; 100 means timeout.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    launch(op, a, b);
    wait_valid(lat);
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b want 0", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", rsp_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
    tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL rst_err got %b want 0", rsp_err); end
    tests++; if (rsp_result !== '0) begin fails++; $display("FAIL rst_result got %h want 0", rsp_result); end
    rst = 1'b0;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready got %b want 1", req_ready); end
  endtask

  task automatic test_basic();
    int lat;
    issue(ALU_CLMUL, 64'd3, 64'd3, lat);
    tests++; if (lat != N + 1) begin fails++; $display("FAIL basic_latency got %0d want %0d", lat, N + 1); end
    tests++; if (rsp_result !== 64'd5) begin fails++; $display("FAIL basic_result got %h want 5", rsp_result); end
    tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL basic_err got %b want 0", rsp_err); end
    take();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop got %b want 0", rsp_valid); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_back got %b want 1", req_ready); end
  endtask

  task automatic test_all_ones();
    logic [6:0] ops [3];
    logic [W:0] exp;
    int lat;
    ops[0] = ALU_CLMUL; ops[1] = ALU_CLMULH; ops[2] = ALU_CLMULR;
    for (int i = 0; i < 3; i++) begin
      exp = model(ops[i], '1, '1);
      issue(ops[i], '1, '1, lat);
      tests++; if (rsp_result !== exp[W-1:0]) begin fails++; $display("FAIL ones_op%0d got %h want %h", i, rsp_result, exp[W-1:0]); end
      take();
    end
  endtask

  task automatic test_shift_boundary();
    int lat;
    issue(ALU_CLMUL, 64'h8000_0000_0000_0000, 64'd2, lat);
    tests++; if (rsp_result !== 64'd0) begin fails++; $display("FAIL shift_clmul got %h want 0", rsp_result); end
    take();
    issue(ALU_CLMULH, 64'h8000_0000_0000_0000, 64'd2, lat);
    tests++; if (rsp_result !== 64'd1) begin fails++; $display("FAIL shift_clmulh got %h want 1", rsp_result); end
    take();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b;
    logic [W:0] exp;
    int lat, bad;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    exp = model(ALU_CLMULH, a, b);
    issue(ALU_CLMULH, a, b, lat);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_result !== exp[W-1:0] || req_ready !== 1'b0 || rsp_err !== 1'b0) bad++;
      step();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL bp_hold bad_cycles got %0d want 0 (result %h want %h)", bad, rsp_result, exp[W-1:0]); end
    tests++; if (rsp_result !== exp[W-1:0]) begin fails++; $display("FAIL bp_result got %h want %h", rsp_result, exp[W-1:0]); end
    take();
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", req_ready); end
  endtask

  task automatic test_flush();
    int lat, seen;
    launch(ALU_CLMUL, 64'd7, 64'd9);
    for (int i = 0; i < 7; i++) step();
    flush = 1'b1;
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL flush_run_ready got %b want 0", req_ready); end
    step();
    flush = 1'b0;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL flush_ready_next got %b want 1", req_ready); end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (rsp_valid === 1'b1) seen++;
      step();
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL flush_no_valid got %0d valid cycles want 0", seen); end
    issue(ALU_CLMUL, 64'd5, 64'd3, lat);
    tests++; if (lat != N + 1) begin fails++; $display("FAIL flush_new_latency got %0d want %0d", lat, N + 1); end
    tests++; if (rsp_result !== 64'hF) begin fails++; $display("FAIL flush_new_result got %h want f", rsp_result); end
    take();
  endtask

  task automatic test_error_op();
    int lat, seen;
    issue(ALU_ADD, 64'd11, 64'd22, lat);
    tests++; if (lat != 1) begin fails++; $display("FAIL err_latency got %0d want 1", lat); end
    tests++; if (rsp_err !== 1'b1) begin fails++; $display("FAIL err_flag got %b want 1", rsp_err); end
    tests++; if (rsp_result !== '0) begin fails++; $display("FAIL err_result got %h want 0", rsp_result); end
    take();
    req_valid = 1'b1;
    req_op    = ALU_CLMUL;
    flush     = 1'b1;
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL flush_idle_ready got %b want 0", req_ready); end
    step();
    req_valid = 1'b0;
    flush     = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_idle_busy got %b want 0", busy); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) seen++;
      step();
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL flush_idle_no_valid got %0d want 0", seen); end
  endtask

  task automatic test_reset_mid_run();
    launch(ALU_CLMULR, 64'hDEAD_BEEF, 64'h1234_5678);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_outputs got busy=%b valid=%b ready=%b want 0 0 0", busy, rsp_valid, req_ready); end
    step();
    rst = 1'b0;
    #1;
    tests++; if (req_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL rst_mid_idle got ready=%b busy=%b want 1 0", req_ready, busy); end
  endtask

  task automatic test_back_to_back();
    int lat, c1, c2;
    launch(ALU_CLMUL, 64'h55, 64'h0F);
    c1 = cyc;
    wait_valid(lat);
    take();
    launch(ALU_CLMULH, '1, 64'h3);
    c2 = cyc;
    tests++; if (c2 - c1 != N + 2) begin fails++; $display("FAIL b2b_spacing got %0d want %0d", c2 - c1, N + 2); end
    wait_valid(lat);
    tests++; if (rsp_result !== 64'h1) begin fails++; $display("FAIL b2b_second_result got %h want 1", rsp_result); end
    take();
  endtask

  task automatic test_random();
    logic [6:0]   ops [5];
    logic [6:0]   op;
    logic [W-1:0] a, b;
    logic [W:0]   exp;
    int lat, hold;
    ops[0] = ALU_CLMUL; ops[1] = ALU_CLMULH; ops[2] = ALU_CLMULR; ops[3] = ALU_XOR; ops[4] = ALU_SLT;
    for (int t = 0; t < 30; t++) begin
      op = ops[$urandom_range(0, 4)];
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if (t % 7 == 3) a = '1;
      exp = model(op, a, b);
      issue(op, a, b, lat);
      tests++; if (lat != (exp[W] ? 1 : N + 1)) begin fails++; $display("FAIL rand%0d_latency got %0d want %0d", t, lat, exp[W] ? 1 : N + 1); end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) step();
      tests++; if (rsp_result !== exp[W-1:0] || rsp_err !== exp[W]) begin fails++; $display("FAIL rand%0d_result op=%0d got %h/%b want %h/%b", t, op, rsp_result, rsp_err, exp[W-1:0], exp[W]); end
      take();
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    flush     = 1'b0;
    rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_all_ones();
    test_shift_boundary();
    test_backpressure();
    test_flush();
    test_error_op();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clmul_sequencer.md
# clmul_sequencer

Multi-cycle sequencer for the carry-less multiply group of `op_alu_e`: `ALU_CLMUL`, `ALU_CLMULH` and `ALU_CLMULR`. It sits beside the single-cycle ALU in the execute stage and accepts one operation per valid/ready handshake. It iterates over `rs2` a fixed number of bits per cycle, accumulating a 2×WIDTH carry-less product. It holds the selected result until the consumer takes it, and a flush input discards in-flight work.

## Interface
Parameters:
- `WIDTH`, default `riscv_pkg::WIDTH` (64): operand and result width.
- `BITS_PER_CYCLE`, default 4: `rs2` bits consumed per RUN cycle. Must divide `WIDTH`; any other value is an elaboration error.

Ports:
- `clk`, input, 1: the only clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `req_valid_i`, input, 1: request valid.
- `req_ready_o`, output, 1: sequencer can accept a request.
- `req_op_i`, input, 7: `op_alu_e` operation.
- `req_a_i`, input, WIDTH: rs1 operand.
- `req_b_i`, input, WIDTH: rs2 operand.
- `flush_i`, input, 1: abort any in-flight or pending operation.
- `rsp_valid_o`, output, 1: result valid.
- `rsp_ready_i`, input, 1: consumer accepts the result.
- `rsp_result_o`, output, WIDTH: result.
- `rsp_err_o`, output, 1: the accepted op was not one of the three CLMUL ops.
- `busy_o`, output, 1: state is not IDLE.

## Operation
- N = WIDTH/BITS_PER_CYCLE. Internal registers: `a`, `b`, `op`, 2×WIDTH accumulator `prod`, and iteration counter `cnt` (clog2(N) bits).
- States:
  - **IDLE**: `req_ready_o` = 1.
    - Accept on `req_valid_i && req_ready_o`.
    - Latch `a`, `b`, `op`; clear `prod` and `cnt`.
    - CLMUL-group op → go to RUN; any other op → go to DONE with `rsp_err_o` = 1 and result 0.
  - **RUN**: each cycle, for i = 0..BITS_PER_CYCLE−1, with k = cnt·BITS_PER_CYCLE + i:
    - If `b[k]`, then `prod ^= zero_extend(a) << k`.
    - `cnt` increments each cycle. The RUN cycle with `cnt` = N−1 transitions to DONE.
  - **DONE**: `rsp_valid_o` = 1. Go to IDLE on `rsp_ready_i`, otherwise hold.
- Result selection, registered on entry to DONE and stable while `rsp_valid_o` is high:
  - CLMUL → `prod[WIDTH-1:0]`
  - CLMULH → `prod[2*WIDTH-1:WIDTH]`
  - CLMULR → `prod[2*WIDTH-2:WIDTH-1]`
- `rsp_err_o` is 0 for the three CLMUL ops.
- Latency is fixed and independent of operand values; there is no early termination.
- `flush_i` in any state → IDLE on the next edge.
  - `rsp_valid_o` drops on that edge and the result is discarded.
  - `req_ready_o` is forced to 0 while `flush_i` = 1, so a simultaneous request is never accepted.
- Reset drives the state to IDLE and clears `prod`, `cnt`, the result and `rsp_err_o`.

## Timing
- While `rst` = 1: `req_ready_o`, `rsp_valid_o`, `busy_o` and `rsp_err_o` are all 0; `rsp_result_o` = 0.
- In the first cycle after `rst` falls: `req_ready_o` = 1.
- With the request handshake in cycle c:
  - RUN occupies cycles c+1 .. c+N.
  - `rsp_valid_o` = 1 from cycle c+N+1.
  - With the defaults (N = 16), `rsp_valid_o` rises at c+17.
- Erroring op: `rsp_valid_o` = 1 from cycle c+1.
- Response handshake in cycle d: `rsp_valid_o` = 0 and `req_ready_o` = 1 in cycle d+1. There is no same-cycle re-accept, so back-to-back throughput is one op per N+2 cycles.
- `req_ready_o` depends only on state and `flush_i`, never on `req_valid_i`.
- Holding `rsp_ready_i` = 0 keeps `rsp_valid_o`, `rsp_result_o` and `rsp_err_o` constant indefinitely.
- `busy_o` = 1 in RUN and DONE.
- `rst` asserted mid-RUN or in DONE has the same effect as a flush, plus clearing all registers.

## Test plan
- CLMUL with a = 3, b = 3 → `rsp_result_o` = 5, `rsp_err_o` = 0, `rsp_valid_o` rising exactly 17 cycles after the accept (defaults).
- a = b = 0xFFFF_FFFF_FFFF_FFFF:
  - CLMUL → 0x5555_5555_5555_5555
  - CLMULH → 0x5555_5555_5555_5555
  - CLMULR → 0xAAAA_AAAA_AAAA_AAAA
- CLMUL with a = 0x8000_0000_0000_0000, b = 2, then CLMULH with the same operands → 0, then 1. Checks the shift boundary.
- Backpressure: hold `rsp_ready_i` low for 5 cycles after `rsp_valid_o` → result unchanged each cycle and `req_ready_o` = 0. Then release → `req_ready_o` = 1 the next cycle.
- Flush on the 8th RUN cycle → `rsp_valid_o` never asserts and `req_ready_o` = 1 the next cycle. A new CLMUL(5,3) then yields 0xF with full latency.
- `ALU_ADD` request → `rsp_valid_o` = 1 one cycle after the accept, `rsp_err_o` = 1, `rsp_result_o` = 0. Separately, `req_valid_i` asserted together with `flush_i` in IDLE → not accepted.
